// File: rtl/iua_cdr_if.sv
// Link between the iua_phy capture stage and the CDR: two line samples in,
// strobed decoded bits plus status out.
interface iua_cdr_if;
    logic [1:0] cap;
    logic       bit_data;
    logic       bit_stb;
    logic       stuff_err;
    logic       active;

    modport master (output cap, input bit_data, bit_stb, stuff_err, active);
    modport slave  (input cap, output bit_data, bit_stb, stuff_err, active);
endinterface

// File: rtl/iua_cdr.sv
// Clock/data recovery: edge-resynchronised phase tracking over two samples per
// clock, mid-bit sampling, NRZI decode and bit unstuffing.
module iua_cdr #(
    parameter int PERIOD    = 8,
    parameter int IDLE_BITS = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    iua_cdr_if.slave bus
);
    localparam int IDLE_MAX = IDLE_BITS * PERIOD;
    localparam int PW       = $clog2(PERIOD);
    localparam int IW       = $clog2(IDLE_MAX + 1);
    localparam logic [PW-1:0] PH_LAST   = PW'(PERIOD - 1);
    localparam logic [PW-1:0] PH_MID    = PW'(PERIOD / 2);
    localparam logic [IW-1:0] IDLE_SAT  = IW'(IDLE_MAX);
    localparam logic [IW-1:0] IDLE_NEAR = IW'(IDLE_MAX - 2);

    logic          prev_q, prev_d;
    logic [PW-1:0] ph_q, ph_d, ph0;
    logic [IW-1:0] idle_q, idle_d;
    logic          active_q, active_d;
    logic          lvl_q, lvl_d;
    logic [2:0]    ones_q, ones_d;
    logic          data_q, data_d;
    logic          stb_q, stb_d;
    logic          err_q, err_d;
    logic          edge0, edge1, hit0, hit1, hit, smp, raw;

    // Phase tracking for both samples in time order, plus line-activity timing.
    always_comb begin
        edge0  = bus.cap[0] != prev_q;
        ph0    = edge0 ? '0 : ((ph_q == PH_LAST) ? '0 : ph_q + 1'b1);
        edge1  = bus.cap[1] != bus.cap[0];
        ph_d   = edge1 ? '0 : ((ph0 == PH_LAST) ? '0 : ph0 + 1'b1);
        hit0   = ph0 == PH_MID;
        hit1   = ph_d == PH_MID;
        hit    = hit0 | hit1;
        smp    = hit1 ? bus.cap[1] : bus.cap[0];
        raw    = smp == lvl_q;
        prev_d = bus.cap[1];
        lvl_d  = hit ? smp : lvl_q;

        idle_d   = '0;
        active_d = 1'b1;
        if (!(edge0 | edge1)) begin
            idle_d   = (idle_q >= IDLE_NEAR) ? IDLE_SAT : idle_q + IW'(2);
            active_d = (idle_d == IDLE_SAT) ? 1'b0 : active_q;
        end
    end

    // Unstuffing runs on the pre-update activity flag, so the sample point in
    // the cycle where activity times out is still delivered.
    always_comb begin
        stb_d  = 1'b0;
        err_d  = 1'b0;
        data_d = data_q;
        ones_d = ones_q;
        if (active_q && hit) begin
            if (ones_q == 3'd6) begin
                ones_d = '0;
                err_d  = raw;
            end else begin
                stb_d  = 1'b1;
                data_d = raw;
                ones_d = raw ? ones_q + 3'd1 : '0;
            end
        end
        if (!active_d) begin
            ones_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q   <= 1'b1;
            ph_q     <= '0;
            idle_q   <= '0;
            active_q <= 1'b0;
            lvl_q    <= 1'b1;
            ones_q   <= '0;
            data_q   <= 1'b0;
            stb_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            prev_q   <= prev_d;
            ph_q     <= ph_d;
            idle_q   <= idle_d;
            active_q <= active_d;
            lvl_q    <= lvl_d;
            ones_q   <= ones_d;
            data_q   <= data_d;
            stb_q    <= stb_d;
            err_q    <= err_d;
        end
    end

    assign bus.bit_data  = data_q;
    assign bus.bit_stb   = stb_q;
    assign bus.stuff_err = err_q;
    assign bus.active    = active_q;
endmodule

// File: tb/tb_iua_cdr.sv
// Self-checking bench for iua_cdr: sample-stream stimulus compared against a
// behavioural model plus fixed expectations for the named scenarios.
module tb_iua_cdr;
    localparam int PERIOD     = 8;
    localparam int IDLE_BITS  = 8;
    localparam int IDLE_LIMIT = IDLE_BITS * PERIOD;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    iua_cdr_if bus ();

    iua_cdr #(.PERIOD(PERIOD), .IDLE_BITS(IDLE_BITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int   m_idx, m_last_edge, m_cycle, m_edge_cycle, m_ones;
    logic m_last, m_lvl, m_active;

    logic       sq[$];
    logic       cur_lvl, last_pushed;
    int         push_count, last_change;
    logic [3:0] obs_q[$], exp_q[$];
    logic       obs_bits[$];
    int         err_count;

    task automatic model_reset();
        m_idx        = 0;
        m_last_edge  = -1;
        m_cycle      = 0;
        m_edge_cycle = 0;
        m_ones       = 0;
        m_last       = 1'b1;
        m_lvl        = 1'b1;
        m_active     = 1'b0;
    endtask

    // Phase is the distance in samples from the most recent edge, modulo PERIOD.
    task automatic model_cycle(input logic [1:0] c, output logic [3:0] e);
        logic hit, val, edge_seen, was_active, raw, stb, err, data;
        hit = 1'b0; val = 1'b0; edge_seen = 1'b0; stb = 1'b0; err = 1'b0; data = 1'b0;
        was_active = m_active;
        m_cycle++;
        for (int k = 0; k < 2; k++) begin
            if (c[k] !== m_last) begin
                m_last_edge = m_idx;
                edge_seen   = 1'b1;
            end
            if ((m_idx - m_last_edge) % PERIOD == PERIOD / 2) begin
                hit = 1'b1;
                val = c[k];
            end
            m_last = c[k];
            m_idx++;
        end
        if (edge_seen) begin
            m_edge_cycle = m_cycle;
            m_active     = 1'b1;
        end else if (2 * (m_cycle - m_edge_cycle) >= IDLE_LIMIT) begin
            m_active = 1'b0;
        end
        if (hit) begin
            raw   = (val == m_lvl);
            m_lvl = val;
            if (was_active) begin
                if (m_ones == 6) begin
                    m_ones = 0;
                    err    = raw;
                end else begin
                    stb    = 1'b1;
                    data   = raw;
                    m_ones = raw ? m_ones + 1 : 0;
                end
            end
        end
        if (!m_active) m_ones = 0;
        e = {m_active, stb, err, data};
    endtask

    task automatic step(input logic [1:0] c);
        logic [3:0] e;
        @(negedge clk);
        bus.cap = c;
        if (!rst_n) begin
            model_reset();
            e = 4'b0;
        end else begin
            model_cycle(c, e);
        end
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        obs_q.push_back({bus.active, bus.bit_stb, bus.stuff_err, bus.bit_stb & bus.bit_data});
        if (bus.bit_stb) obs_bits.push_back(bus.bit_data);
        if (bus.stuff_err) err_count++;
    endtask

    task automatic push_level(input logic lv, input int n);
        for (int i = 0; i < n; i++) begin
            if (lv !== last_pushed) last_change = push_count;
            sq.push_back(lv);
            last_pushed = lv;
            push_count++;
        end
    endtask

    task automatic send_bit(input logic b, input int n);
        if (!b) cur_lvl = ~cur_lvl;
        push_level(cur_lvl, n);
    endtask

    task automatic send_sync(input int idle_samples);
        push_level(1'b1, idle_samples);
        for (int i = 0; i < 8; i++) send_bit(i == 7, PERIOD);
    endtask

    task automatic run_samples(input int max_cycles);
        int n = 0;
        while (sq.size() >= 2 && n < max_cycles) begin
            step({sq[1], sq[0]});
            void'(sq.pop_front());
            void'(sq.pop_front());
            n++;
        end
    endtask

    task automatic start_test();
        sq.delete(); obs_q.delete(); exp_q.delete(); obs_bits.delete();
        err_count   = 0;
        cur_lvl     = 1'b1;
        last_pushed = 1'b1;
        push_count  = 0;
        last_change = -1;
        @(negedge clk);
        rst_n   = 1'b0;
        bus.cap = 2'b11;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        obs_q.delete(); exp_q.delete();
        for (int i = 0; i < 6; i++) step(2'($urandom_range(0, 3)));
        for (int i = 0; i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== 4'b0) begin
                n_fail++;
                $display("[TB] FAIL reset_hold cycle %0d: got %b expected 0000", i, obs_q[i]);
            end
        end
    endtask

    task automatic test_sync();
        logic want[$];
        start_test();
        send_sync(16);
        send_bit(1'b0, PERIOD);
        send_bit(1'b0, PERIOD);
        run_samples(1000);
        want = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        for (int i = 0; i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("[TB] FAIL sync_model cycle %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (obs_q[7][3] !== 1'b0 || obs_q[8][3] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL sync_active_rise: got %b%b expected 01", obs_q[7][3], obs_q[8][3]);
        end
        n_checks++;
        if (obs_q[9][2] !== 1'b0 || obs_q[10][2] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL sync_first_strobe: got %b%b expected 01", obs_q[9][2], obs_q[10][2]);
        end
        n_checks++;
        if (obs_bits.size() != want.size()) begin
            n_fail++;
            $display("[TB] FAIL sync_bit_count: got %0d expected %0d", obs_bits.size(), want.size());
        end
        for (int i = 0; i < want.size() && i < obs_bits.size(); i++) begin
            n_checks++;
            if (obs_bits[i] !== want[i]) begin
                n_fail++;
                $display("[TB] FAIL sync_bit %0d: got %b expected %b", i, obs_bits[i], want[i]);
            end
        end
    endtask

    task automatic test_half_cycle();
        logic want[$];
        start_test();
        send_sync(17);
        send_bit(1'b0, PERIOD);
        send_bit(1'b0, PERIOD);
        push_level(cur_lvl, 1);
        run_samples(1000);
        want = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        for (int i = 0; i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("[TB] FAIL half_model cycle %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (obs_bits.size() != want.size()) begin
            n_fail++;
            $display("[TB] FAIL half_bit_count: got %0d expected %0d", obs_bits.size(), want.size());
        end
        for (int i = 0; i < want.size() && i < obs_bits.size(); i++) begin
            n_checks++;
            if (obs_bits[i] !== want[i]) begin
                n_fail++;
                $display("[TB] FAIL half_bit %0d: got %b expected %b", i, obs_bits[i], want[i]);
            end
        end
    endtask

    task automatic test_stuffing();
        logic want[$];
        start_test();
        send_sync(16);
        for (int i = 0; i < 5; i++) send_bit(1'b1, PERIOD);
        send_bit(1'b0, PERIOD);
        send_bit(1'b0, PERIOD);
        send_bit(1'b0, PERIOD);
        run_samples(1000);
        want = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0};
        for (int i = 0; i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("[TB] FAIL stuff_model cycle %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (err_count != 0) begin
            n_fail++;
            $display("[TB] FAIL stuff_no_err: got %0d errors expected 0", err_count);
        end
        n_checks++;
        if (obs_bits.size() != want.size()) begin
            n_fail++;
            $display("[TB] FAIL stuff_bit_count: got %0d expected %0d", obs_bits.size(), want.size());
        end
        for (int i = 0; i < want.size() && i < obs_bits.size(); i++) begin
            n_checks++;
            if (obs_bits[i] !== want[i]) begin
                n_fail++;
                $display("[TB] FAIL stuff_bit %0d: got %b expected %b", i, obs_bits[i], want[i]);
            end
        end
    endtask

    task automatic test_stuff_err();
        logic want[$];
        start_test();
        send_sync(16);
        for (int i = 0; i < 6; i++) send_bit(1'b1, PERIOD);
        send_bit(1'b0, PERIOD);
        send_bit(1'b0, PERIOD);
        run_samples(1000);
        want = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0};
        for (int i = 0; i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("[TB] FAIL err_model cycle %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (err_count != 1) begin
            n_fail++;
            $display("[TB] FAIL err_pulse_count: got %0d expected 1", err_count);
        end
        n_checks++;
        if (obs_bits.size() != want.size()) begin
            n_fail++;
            $display("[TB] FAIL err_bit_count: got %0d expected %0d", obs_bits.size(), want.size());
        end
        for (int i = 0; i < want.size() && i < obs_bits.size(); i++) begin
            n_checks++;
            if (obs_bits[i] !== want[i]) begin
                n_fail++;
                $display("[TB] FAIL err_bit %0d: got %b expected %b", i, obs_bits[i], want[i]);
            end
        end
    endtask

    // Alternating short/long bits with a proper stuffing encoder, then a quiet line.
    task automatic test_jitter_idle();
        logic want[$];
        int   tx_ones, alt, edge_cycle;
        logic b;
        start_test();
        send_sync(16);
        want = '{0, 0, 0, 0, 0, 0, 0, 1};
        tx_ones = 1;
        alt     = 0;
        for (int i = 0; i < 24; i++) begin
            b = 1'($urandom_range(0, 1));
            send_bit(b, (alt % 2 == 0) ? PERIOD - 2 : PERIOD + 2);
            alt++;
            want.push_back(b);
            tx_ones = b ? tx_ones + 1 : 0;
            if (tx_ones == 6) begin
                send_bit(1'b0, (alt % 2 == 0) ? PERIOD - 2 : PERIOD + 2);
                alt++;
                tx_ones = 0;
            end
        end
        push_level(cur_lvl, 2 * (IDLE_LIMIT / 2 + 8));
        if (push_count % 2 != 0) push_level(cur_lvl, 1);
        edge_cycle = last_change / 2;
        run_samples(2000);
        for (int i = 0; i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("[TB] FAIL jitter_model cycle %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
            end
        end
        for (int i = 0; i < want.size(); i++) begin
            n_checks++;
            if (i >= obs_bits.size() || obs_bits[i] !== want[i]) begin
                n_fail++;
                $display("[TB] FAIL jitter_bit %0d: got %b expected %b", i,
                         (i < obs_bits.size()) ? obs_bits[i] : 1'bx, want[i]);
            end
        end
        n_checks++;
        if (obs_q[edge_cycle + IDLE_BITS * PERIOD / 2 - 1][3] !== 1'b1 ||
            obs_q[edge_cycle + IDLE_BITS * PERIOD / 2][3] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL idle_active_fall: got %b%b expected 10",
                     obs_q[edge_cycle + IDLE_BITS * PERIOD / 2 - 1][3],
                     obs_q[edge_cycle + IDLE_BITS * PERIOD / 2][3]);
        end
        for (int i = edge_cycle + IDLE_BITS * PERIOD / 2; i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i][2:1] !== 2'b00) begin
                n_fail++;
                $display("[TB] FAIL idle_quiet cycle %0d: got %b expected 00", i, obs_q[i][2:1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int rel;
        start_test();
        send_sync(16);
        for (int i = 0; i < 12; i++) send_bit(1'($urandom_range(0, 1)), PERIOD);
        run_samples(44);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.active, bus.bit_stb, bus.stuff_err, bus.bit_data} !== 4'b0) begin
            n_fail++;
            $display("[TB] FAIL midreset_async: got %b expected 0000",
                     {bus.active, bus.bit_stb, bus.stuff_err, bus.bit_data});
        end
        run_samples(2);
        rst_n = 1'b1;
        rel   = obs_q.size();
        run_samples(1000);
        for (int i = 0; i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("[TB] FAIL midreset_model cycle %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
            end
        end
        for (int i = rel; i < rel + 2; i++) begin
            n_checks++;
            if (obs_q[i][2:1] !== 2'b00) begin
                n_fail++;
                $display("[TB] FAIL midreset_no_strobe cycle %0d: got %b expected 00", i, obs_q[i][2:1]);
            end
        end
    endtask

    task automatic test_random_packet();
        for (int it = 0; it < 3; it++) begin
            start_test();
            push_level(1'b1, 2 * $urandom_range(4, 12));
            for (int i = 0; i < 30; i++)
                send_bit(1'($urandom_range(0, 1)), PERIOD - 2 + $urandom_range(0, 4));
            push_level(cur_lvl, IDLE_LIMIT + 16);
            if (push_count % 2 != 0) push_level(cur_lvl, 1);
            run_samples(2000);
            for (int i = 0; i < obs_q.size(); i++) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("[TB] FAIL random_model pkt %0d cycle %0d: got %b expected %b",
                             it, i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        bus.cap = 2'b11;
        test_reset();
        test_sync();
        test_half_cycle();
        test_stuffing();
        test_stuff_err();
        test_jitter_idle();
        test_reset_mid();
        test_random_packet();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
